// File: rtl/control_unit_mc.sv
// Multicycle MIPS-subset control FSM with configurable memory latency,
// branches, loads/stores, jumps and overflow/invalid-opcode exceptions.
module control_unit_mc #(
    parameter int MEM_WAIT = 1,
    parameter int STATE_W  = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         OpCode,
    input  logic [5:0]         Func,
    input  logic               Overflow,
    input  logic               Zero,
    output logic [2:0]         SrcAddressMem,
    output logic               MemOp,
    output logic               WriteMDR,
    output logic               IRWrite,
    output logic               WriteA,
    output logic               WriteB,
    output logic               WriteALUOut,
    output logic               EPCWrite,
    output logic               PCWrite,
    output logic               RegWrite,
    output logic [2:0]         RegDst,
    output logic [1:0]         ALUSrcA,
    output logic [2:0]         ALUSrcB,
    output logic [2:0]         ALUOp,
    output logic [1:0]         PCSource,
    output logic [2:0]         MemToReg,
    output logic [STATE_W-1:0] dbg_state
);

    typedef enum logic [STATE_W-1:0] {
        RESET, FETCH, WAIT_I, IR_LOAD, DECODE,
        EX_ADD, EX_SUB, EX_AND, EX_SLT, EX_ADDI, EX_ADDIU,
        WB_RD, WB_RT, JR, BEQ, BNE, JUMP,
        MEM_ADDR, ST, LD_ISSUE, WAIT_D, LD_CAP, LD_WB,
        EXC_OVF, EXC_INV, EXC_WAIT, EXC_CAP, EXC_PC
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT - 1);

    state_t     state, nxt;
    logic [3:0] wcnt;
    logic       slt_q;
    logic [2:0] exc_vec;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= RESET;
            wcnt    <= 4'd0;
            slt_q   <= 1'b0;
            exc_vec <= 3'd0;
        end else begin
            state <= nxt;
            case (state)
                FETCH, LD_ISSUE, EXC_OVF, EXC_INV: wcnt <= WAIT_INIT;
                WAIT_I, WAIT_D, EXC_WAIT: if (wcnt != 4'd0) wcnt <= wcnt - 4'd1;
                default: ;
            endcase
            if (state == DECODE) slt_q <= (OpCode == 6'h00) && (Func == 6'h2a);
            // exception vector is latched so the address stays put until the handler PC loads
            if (state == EXC_OVF) exc_vec <= 3'd3;
            if (state == EXC_INV) exc_vec <= 3'd2;
        end
    end

    always_comb begin
        nxt           = state;
        SrcAddressMem = 3'd0;
        MemOp         = 1'b0;
        WriteMDR      = 1'b0;
        IRWrite       = 1'b0;
        WriteA        = 1'b0;
        WriteB        = 1'b0;
        WriteALUOut   = 1'b0;
        EPCWrite      = 1'b0;
        PCWrite       = 1'b0;
        RegWrite      = 1'b0;
        RegDst        = 3'd0;
        ALUSrcA       = 2'd0;
        ALUSrcB       = 3'd0;
        ALUOp         = 3'd0;
        PCSource      = 2'd0;
        MemToReg      = 3'd0;
        case (state)
            RESET:    begin RegWrite = 1'b1; RegDst = 3'd3; MemToReg = 3'd7; nxt = FETCH; end
            FETCH:    begin ALUSrcB = 3'd1; ALUOp = 3'd1; PCWrite = 1'b1; nxt = WAIT_I; end
            WAIT_I:   if (wcnt == 4'd0) nxt = IR_LOAD;
            IR_LOAD:  begin IRWrite = 1'b1; WriteMDR = 1'b1; nxt = DECODE; end
            DECODE: begin
                WriteA = 1'b1; WriteB = 1'b1; WriteALUOut = 1'b1;
                ALUSrcB = 3'd3; ALUOp = 3'd1;
                nxt = EXC_INV;
                case (OpCode)
                    6'h00: case (Func)
                        6'h20:   nxt = EX_ADD;
                        6'h22:   nxt = EX_SUB;
                        6'h24:   nxt = EX_AND;
                        6'h2a:   nxt = EX_SLT;
                        6'h08:   nxt = JR;
                        default: nxt = EXC_INV;
                    endcase
                    6'h08:   nxt = EX_ADDI;
                    6'h09:   nxt = EX_ADDIU;
                    6'h04:   nxt = BEQ;
                    6'h05:   nxt = BNE;
                    6'h23,
                    6'h2b:   nxt = MEM_ADDR;
                    6'h02:   nxt = JUMP;
                    default: nxt = EXC_INV;
                endcase
            end
            EX_ADD:   begin ALUSrcA = 2'd1; WriteALUOut = 1'b1; ALUOp = 3'd1; nxt = Overflow ? EXC_OVF : WB_RD; end
            EX_SUB:   begin ALUSrcA = 2'd1; WriteALUOut = 1'b1; ALUOp = 3'd2; nxt = Overflow ? EXC_OVF : WB_RD; end
            EX_AND:   begin ALUSrcA = 2'd1; WriteALUOut = 1'b1; ALUOp = 3'd3; nxt = WB_RD; end
            EX_SLT:   begin ALUSrcA = 2'd1; WriteALUOut = 1'b1; ALUOp = 3'd7; nxt = WB_RD; end
            EX_ADDI:  begin
                ALUSrcA = 2'd1; ALUSrcB = 3'd2; ALUOp = 3'd1; WriteALUOut = 1'b1;
                nxt = Overflow ? EXC_OVF : WB_RT;
            end
            EX_ADDIU: begin ALUSrcA = 2'd1; ALUSrcB = 3'd4; ALUOp = 3'd1; WriteALUOut = 1'b1; nxt = WB_RT; end
            WB_RD:    begin RegDst = 3'd1; RegWrite = 1'b1; MemToReg = slt_q ? 3'd6 : 3'd0; nxt = FETCH; end
            WB_RT:    begin RegWrite = 1'b1; nxt = FETCH; end
            JR:       begin ALUSrcA = 2'd1; PCWrite = 1'b1; nxt = FETCH; end
            BEQ:      begin ALUSrcA = 2'd1; ALUOp = 3'd2; PCSource = 2'd1; PCWrite = Zero;  nxt = FETCH; end
            BNE:      begin ALUSrcA = 2'd1; ALUOp = 3'd2; PCSource = 2'd1; PCWrite = !Zero; nxt = FETCH; end
            JUMP:     begin PCSource = 2'd2; PCWrite = 1'b1; nxt = FETCH; end
            MEM_ADDR: begin
                ALUSrcA = 2'd1; ALUSrcB = 3'd2; ALUOp = 3'd1; WriteALUOut = 1'b1;
                nxt = (OpCode == 6'h2b) ? ST : LD_ISSUE;
            end
            ST:       begin SrcAddressMem = 3'd1; MemOp = 1'b1; nxt = FETCH; end
            LD_ISSUE: begin SrcAddressMem = 3'd1; nxt = WAIT_D; end
            WAIT_D:   if (wcnt == 4'd0) nxt = LD_CAP;
            LD_CAP:   begin SrcAddressMem = 3'd1; WriteMDR = 1'b1; nxt = LD_WB; end
            LD_WB:    begin RegWrite = 1'b1; MemToReg = 3'd1; nxt = FETCH; end
            EXC_OVF:  begin SrcAddressMem = 3'd3; ALUSrcB = 3'd1; ALUOp = 3'd2; EPCWrite = 1'b1; nxt = EXC_WAIT; end
            EXC_INV:  begin SrcAddressMem = 3'd2; ALUSrcB = 3'd1; ALUOp = 3'd2; EPCWrite = 1'b1; nxt = EXC_WAIT; end
            EXC_WAIT: begin SrcAddressMem = exc_vec; if (wcnt == 4'd0) nxt = EXC_CAP; end
            EXC_CAP:  begin SrcAddressMem = exc_vec; WriteMDR = 1'b1; nxt = EXC_PC; end
            EXC_PC:   begin SrcAddressMem = exc_vec; PCSource = 2'd3; PCWrite = 1'b1; nxt = FETCH; end
            default:  nxt = RESET;
        endcase
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_control_unit_mc.sv
// Directed bench for control_unit_mc: three instances (MEM_WAIT 1/3/2) share
// stimulus; per-cycle output traces are checked against hand-derived schedules.
module tb_control_unit_mc;

    localparam int NI = 3;
    localparam int NC = 24;

    typedef struct packed {
        logic [2:0] sam;
        logic       memop, mdr, irw, wa, wb, wao, epc, pcw, rw;
        logic [2:0] rd;
        logic [1:0] asa;
        logic [2:0] asb, aop;
        logic [1:0] pcs;
        logic [2:0] mtr;
        logic [6:0] st;
    } snap_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] OpCode = 6'h0;
    logic [5:0] Func = 6'h0;
    logic       Overflow = 1'b0;
    logic       Zero = 1'b0;

    snap_t o  [NI];
    snap_t tr [NI][NC];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int MW = (g == 0) ? 1 : (g == 1) ? 3 : 2;
        logic [2:0] sam, rd, asb, aop, mtr;
        logic       memop, mdr, irw, wa, wb, wao, epc, pcw, rw;
        logic [1:0] asa, pcs;
        logic [6:0] st;
        control_unit_mc #(.MEM_WAIT(MW), .STATE_W(7)) u_dut (
            .clk(clk), .reset(reset), .OpCode(OpCode), .Func(Func),
            .Overflow(Overflow), .Zero(Zero),
            .SrcAddressMem(sam), .MemOp(memop), .WriteMDR(mdr), .IRWrite(irw),
            .WriteA(wa), .WriteB(wb), .WriteALUOut(wao), .EPCWrite(epc),
            .PCWrite(pcw), .RegWrite(rw), .RegDst(rd), .ALUSrcA(asa),
            .ALUSrcB(asb), .ALUOp(aop), .PCSource(pcs), .MemToReg(mtr),
            .dbg_state(st)
        );
        assign o[g] = {sam, memop, mdr, irw, wa, wb, wao, epc, pcw, rw,
                       rd, asa, asb, aop, pcs, mtr, st};
    end

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // leaves the bench 3 time units after a clock edge with the FSM in RESET
    task automatic do_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
    endtask

    // cycle 1 is the FETCH cycle following reset release
    task automatic capture();
        @(posedge clk); #1;
        for (int c = 1; c < NC; c++) begin
            for (int i = 0; i < NI; i++) tr[i][c] = o[i];
            @(posedge clk); #1;
        end
    endtask

    task automatic run(input logic [5:0] op, input logic [5:0] fn,
                       input logic ov, input logic z);
        OpCode = op; Func = fn; Overflow = ov; Zero = z;
        do_reset();
        capture();
    endtask

    function automatic bit is_fetch(input snap_t s);
        return s.pcw && s.asb == 3'd1 && s.aop == 3'd1 && s.asa == 2'd0;
    endfunction

    function automatic int next_fetch(input int i);
        for (int c = 2; c < NC; c++) if (is_fetch(tr[i][c])) return c;
        return -1;
    endfunction

    function automatic int first_irw(input int i);
        for (int c = 1; c < NC; c++) if (tr[i][c].irw) return c;
        return -1;
    endfunction

    // kind 0: any RegWrite, 1: RegWrite to rd, 2: MemOp write
    function automatic int count(input int i, input int last, input int kind);
        int n = 0;
        for (int c = 1; c <= last; c++)
            case (kind)
                0: n += int'(tr[i][c].rw);
                1: n += int'(tr[i][c].rw && tr[i][c].rd == 3'd1);
                default: n += int'(tr[i][c].memop);
            endcase
        return n;
    endfunction

    initial begin
        // reset values and first FETCH
        do_reset();
        chk("rst_regwrite", o[0].rw, 1);
        chk("rst_regdst", o[0].rd, 3);
        chk("rst_memtoreg", o[0].mtr, 7);
        chk("rst_pcwrite", o[0].pcw, 0);
        @(posedge clk); #1;
        chk("fetch_pcwrite", o[0].pcw, 1);
        chk("fetch_alusrcb", o[0].asb, 1);
        chk("fetch_aluop", o[0].aop, 1);

        // add: MEM_WAIT=1 (inst 0) and MEM_WAIT=3 (inst 1)
        run(6'h00, 6'h20, 1'b0, 1'b0);
        chk("add_mw1_irw_cyc", first_irw(0), 3);
        chk("add_mw1_total", next_fetch(0) - 1, 6);
        chk("add_mw1_wbrd", count(0, 5, 1) + count(0, 6, 1) - count(0, 5, 1), 1);
        chk("add_mw1_mtr", tr[0][6].mtr, 0);
        chk("add_mw3_irw_cyc", first_irw(1), 5);
        chk("add_mw3_total", next_fetch(1) - 1, 8);
        chk("add_mw3_wbrd", count(1, 8, 1), 1);

        // slt
        run(6'h00, 6'h2a, 1'b0, 1'b0);
        chk("slt_aluop", tr[0][5].aop, 7);
        chk("slt_regdst", tr[0][6].rd, 1);
        chk("slt_mtr", tr[0][6].mtr, 6);

        // addi with overflow -> EXC_OVF path
        run(6'h08, 6'h00, 1'b1, 1'b0);
        chk("ovf_no_rw", count(0, 9, 0), 0);
        chk("ovf_epcwrite", tr[0][6].epc, 1);
        chk("ovf_sam", tr[0][6].sam, 3);
        chk("ovf_sam_wait", tr[0][7].sam, 3);
        chk("ovf_mdr", tr[0][8].mdr, 1);
        chk("ovf_pcwrite", tr[0][9].pcw, 1);
        chk("ovf_pcsource", tr[0][9].pcs, 3);
        chk("ovf_return", next_fetch(0), 10);

        // addiu ignores overflow
        run(6'h09, 6'h00, 1'b1, 1'b0);
        chk("addiu_alusrcb", tr[0][5].asb, 4);
        chk("addiu_rw", tr[0][6].rw, 1);
        chk("addiu_regdst", tr[0][6].rd, 0);
        chk("addiu_return", next_fetch(0), 7);

        // invalid opcode
        run(6'h3f, 6'h00, 1'b0, 1'b0);
        chk("inv_epcwrite", tr[0][5].epc, 1);
        chk("inv_sam", tr[0][5].sam, 2);
        chk("inv_mdr", tr[0][7].mdr, 1);
        chk("inv_sam_cap", tr[0][7].sam, 2);
        chk("inv_pcsource", tr[0][8].pcs, 3);
        chk("inv_no_rw", count(0, 8, 0), 0);
        chk("inv_return", next_fetch(0), 9);

        // branches
        run(6'h04, 6'h00, 1'b0, 1'b1);
        chk("beq_z1_pcw", tr[0][5].pcw, 1);
        chk("beq_z1_pcs", tr[0][5].pcs, 1);
        chk("beq_return", next_fetch(0), 6);
        run(6'h04, 6'h00, 1'b0, 1'b0);
        chk("beq_z0_pcw", tr[0][5].pcw, 0);
        run(6'h05, 6'h00, 1'b0, 1'b1);
        chk("bne_z1_pcw", tr[0][5].pcw, 0);
        run(6'h05, 6'h00, 1'b0, 1'b0);
        chk("bne_z0_pcw", tr[0][5].pcw, 1);

        // jumps
        run(6'h02, 6'h00, 1'b0, 1'b0);
        chk("j_pcw", tr[0][5].pcw, 1);
        chk("j_pcs", tr[0][5].pcs, 2);
        run(6'h00, 6'h08, 1'b0, 1'b0);
        chk("jr_pcw", tr[0][5].pcw, 1);
        chk("jr_alusrca", tr[0][5].asa, 1);
        chk("jr_pcs", tr[0][5].pcs, 0);

        // lw with MEM_WAIT=2 (inst 2)
        run(6'h23, 6'h00, 1'b0, 1'b0);
        chk("lw_issue_sam", tr[2][7].sam, 1);
        chk("lw_issue_memop", tr[2][7].memop, 0);
        chk("lw_wait2_mdr", tr[2][9].mdr, 0);
        chk("lw_cap_mdr", tr[2][10].mdr, 1);
        chk("lw_cap_sam", tr[2][10].sam, 1);
        chk("lw_wb_rw", tr[2][11].rw, 1);
        chk("lw_wb_mtr", tr[2][11].mtr, 1);
        chk("lw_wb_regdst", tr[2][11].rd, 0);
        chk("lw_return", next_fetch(2), 12);

        // sw
        run(6'h2b, 6'h00, 1'b0, 1'b0);
        chk("sw_memop_once", count(0, 6, 2), 1);
        chk("sw_sam", tr[0][6].sam, 1);
        chk("sw_no_rw", count(0, 6, 0), 0);
        chk("sw_return", next_fetch(0), 7);

        // asynchronous reset while inst 2 sits in WAIT_D
        OpCode = 6'h23; Func = 6'h00;
        do_reset();
        repeat (8) begin @(posedge clk); #1; end
        chk("arst_pre_rw", o[2].rw, 0);
        #2 reset = 1'b0;
        #1;
        chk("arst_rw", o[2].rw, 1);
        chk("arst_regdst", o[2].rd, 3);
        chk("arst_mtr", o[2].mtr, 7);
        reset = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
